// File: rtl/hls_deadlock_pkg.sv
// Shared types for the HLS deadlock report arbiter: FSM state,
// report bundle and the round-robin pick used by the grant stage.
package hls_deadlock_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      REPORT
   } state_e;

   localparam int PERSIST_DEF = 16;
   localparam int IDX_W_MAX   = 5;
   localparam int TS_W_MAX    = 64;

   typedef struct packed {
      logic [IDX_W_MAX-1:0] idx;
      logic [TS_W_MAX-1:0]  ts;
   } rpt_t;

   // First set request at or above ptr, wrapping at n.
   function automatic logic [IDX_W_MAX-1:0] rr_pick(
      input logic [31:0]          req,
      input logic [IDX_W_MAX-1:0] ptr,
      input int unsigned          n
   );
      logic [IDX_W_MAX-1:0] pick;
      logic                 found;
      int unsigned          j;
      pick  = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < 32; k++) begin
         j = 32'(ptr) + k;
         if (j >= n) j = j - n;
         if (k < n && !found && req[j[4:0]]) begin
            pick  = j[4:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/hls_deadlock_report_arbiter_if.sv
// Valid/ready report channel from the arbiter to the readout path.
interface hls_deadlock_report_arbiter_if #(
   parameter int IDX_W = 3,
   parameter int TS_W  = 32
);
   logic             rpt_valid;
   logic             rpt_ready;
   logic [IDX_W-1:0] rpt_idx;
   logic [TS_W-1:0]  rpt_ts;

   modport master (
      output rpt_valid,
      output rpt_idx,
      output rpt_ts,
      input  rpt_ready
   );

   modport slave (
      input  rpt_valid,
      input  rpt_idx,
      input  rpt_ts,
      output rpt_ready
   );
endinterface

// File: rtl/hls_deadlock_persist_filter.sv
// Persistence filter for one monitor flag: pulses confirm once
// when the flag has been held for PERSIST consecutive cycles.
module hls_deadlock_persist_filter #(
   parameter int PERSIST = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   input  logic blk,
   output logic confirm
);

   localparam logic [7:0] CNT_TOP  = 8'(PERSIST);
   localparam logic [7:0] CNT_LAST = 8'(PERSIST - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       run;

   always_comb begin
      run   = enable && blk && !clear;
      cnt_d = cnt_q;
      if (!run) cnt_d = '0;
      else if (cnt_q != CNT_TOP) cnt_d = cnt_q + 8'd1;
      confirm = run && (cnt_q == CNT_LAST);
   end

   always_ff @(posedge clock) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/hls_deadlock_report_arbiter.sv
// Collects confirmed deadlocks from all monitors and serialises
// them round-robin onto a single valid/ready report channel.
module hls_deadlock_report_arbiter
   import hls_deadlock_pkg::*;
#(
   parameter int NUM_MON = 8,
   parameter int IDX_W   = 3,
   parameter int PERSIST = PERSIST_DEF,
   parameter int TS_W    = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 clear,
   input  logic [NUM_MON-1:0]   mon_block,
   hls_deadlock_report_arbiter_if.master rpt,
   output logic [NUM_MON-1:0]   sticky,
   output logic                 deadlock_any
);

   state_e             state_q, state_d;
   logic [TS_W-1:0]    ts_q, ts_d;
   logic [NUM_MON-1:0] confirm;
   logic [NUM_MON-1:0] pending_q, pending_d;
   logic [NUM_MON-1:0] sticky_q, sticky_d;
   logic [NUM_MON-1:0] grant_mask;
   logic [TS_W-1:0]    conf_ts_q [NUM_MON];
   logic [TS_W-1:0]    conf_ts_d [NUM_MON];
   logic [IDX_W-1:0]   ptr_q, ptr_d, pick;
   rpt_t               rpt_q, rpt_d;
   logic               any_q, any_d;

   for (genvar i = 0; i < NUM_MON; i++) begin : g_flt
      hls_deadlock_persist_filter #(
         .PERSIST (PERSIST)
      ) u_flt (
         .clock   (clock),
         .reset   (reset),
         .enable  (enable),
         .clear   (clear),
         .blk     (mon_block[i]),
         .confirm (confirm[i])
      );
   end

   always_comb begin
      ts_d = ts_q;
      if (enable && ts_q != '1) ts_d = ts_q + TS_W'(1);

      pick = IDX_W'(rr_pick(32'(pending_q),
                            IDX_W_MAX'(ptr_q),
                            NUM_MON));

      state_d    = state_q;
      ptr_d      = ptr_q;
      rpt_d      = rpt_q;
      grant_mask = '0;

      unique case (state_q)
         IDLE: begin
            if (enable && |pending_q) state_d = GRANT;
         end
         GRANT: begin
            // Pending may have been cleared on the way in.
            if (|pending_q) begin
               grant_mask[pick] = 1'b1;
               rpt_d.idx = IDX_W_MAX'(pick);
               rpt_d.ts  = TS_W_MAX'(conf_ts_q[pick]);
               ptr_d = (pick == IDX_W'(NUM_MON - 1)) ?
                       '0 : pick + IDX_W'(1);
               state_d = REPORT;
            end else begin
               state_d = IDLE;
            end
         end
         REPORT: begin
            if (rpt.rpt_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Grant clears first so a same-cycle confirm re-arms.
      pending_d = (pending_q & ~grant_mask) | confirm;
      conf_ts_d = conf_ts_q;
      for (int i = 0; i < NUM_MON; i++) begin
         if (confirm[i] && !(pending_q[i] && !grant_mask[i]))
            conf_ts_d[i] = ts_q;
      end

      sticky_d = sticky_q | confirm;
      if (clear) begin
         pending_d = '0;
         sticky_d  = '0;
      end
      any_d = |sticky_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         ts_q      <= '0;
         pending_q <= '0;
         sticky_q  <= '0;
         conf_ts_q <= '{default: '0};
         ptr_q     <= '0;
         rpt_q     <= '0;
         any_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ts_q      <= ts_d;
         pending_q <= pending_d;
         sticky_q  <= sticky_d;
         conf_ts_q <= conf_ts_d;
         ptr_q     <= ptr_d;
         rpt_q     <= rpt_d;
         any_q     <= any_d;
      end
   end

   assign rpt.rpt_valid = (state_q == REPORT);
   assign rpt.rpt_idx   = IDX_W'(rpt_q.idx);
   assign rpt.rpt_ts    = TS_W'(rpt_q.ts);
   assign sticky        = sticky_q;
   assign deadlock_any  = any_q;

endmodule

// File: tb/tb_hls_deadlock_report_arbiter.sv
// Directed bench for the deadlock report arbiter with a
// cycle model of the report stream and literal per-test pins.
module tb_hls_deadlock_report_arbiter;

   localparam int N = 8;
   localparam int P = 16;

   logic         clock;
   logic         reset;
   logic         enable;
   logic         clear;
   logic [N-1:0] mon_block;
   logic [N-1:0] sticky;
   logic         deadlock_any;

   hls_deadlock_report_arbiter_if #(.IDX_W(3), .TS_W(32)) rif ();

   hls_deadlock_report_arbiter #(
      .NUM_MON (N),
      .IDX_W   (3),
      .PERSIST (P),
      .TS_W    (32)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .clear        (clear),
      .mon_block    (mon_block),
      .rpt          (rif),
      .sticky       (sticky),
      .deadlock_any (deadlock_any)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;
   logic [63:0] log_q [$];

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic exp_rep(input string name, input int k,
                          input int idx, input int ts);
      logic [63:0] act;
      act = (k < log_q.size()) ? log_q[k] : '1;
      chk(name, act, {idx[31:0], ts[31:0]});
   endtask

   // Reference model: run lengths, pending set, rr pointer.
   int          run [N];
   logic [31:0] m_cts [N];
   logic [N-1:0] m_pend, m_sticky;
   logic [31:0] m_ts, m_idx, m_rts;
   int          m_ptr;
   bit          m_valid, m_granting, m_any, started;

   initial begin
      logic [N-1:0] cf;
      bit found;
      int j;
      started = 0;
      forever begin
         @(posedge clock);
         if (reset) begin
            started = 1;
            m_pend = 0; m_sticky = 0; m_ts = 0; m_ptr = 0;
            m_valid = 0; m_granting = 0; m_any = 0;
            m_idx = 0; m_rts = 0;
            for (int i = 0; i < N; i++) begin
               run[i] = 0; m_cts[i] = 0;
            end
         end else begin
            cf = 0;
            for (int i = 0; i < N; i++) begin
               if (enable && mon_block[i] && !clear) begin
                  if (run[i] == P - 1) cf[i] = 1'b1;
                  if (run[i] < P) run[i] = run[i] + 1;
               end else begin
                  run[i] = 0;
               end
            end
            m_any = |m_sticky;
            if (m_granting) begin
               m_granting = 0;
               found = 0;
               for (int k = 0; k < N; k++) begin
                  j = (m_ptr + k) % N;
                  if (!found && m_pend[j]) begin
                     found = 1;
                     m_idx = j;
                     m_rts = m_cts[j];
                     m_pend[j] = 1'b0;
                     m_ptr = (j + 1) % N;
                     m_valid = 1;
                  end
               end
            end else if (m_valid) begin
               if (rif.rpt_ready) m_valid = 0;
            end else if (enable && m_pend != 0) begin
               m_granting = 1;
            end
            for (int i = 0; i < N; i++) begin
               if (cf[i]) begin
                  if (!m_pend[i]) m_cts[i] = m_ts;
                  m_pend[i] = 1'b1;
                  m_sticky[i] = 1'b1;
               end
            end
            if (clear) begin
               m_pend = 0; m_sticky = 0;
            end
            if (enable && m_ts != 32'hFFFF_FFFF) m_ts = m_ts + 1;
         end
      end
   end

   // Per-cycle compare, plus hold-stability while stalled.
   initial begin
      bit          hold;
      logic [31:0] h_idx, h_ts;
      hold = 0; h_idx = 0; h_ts = 0;
      forever begin
         @(negedge clock);
         if (started) begin
            chk("rpt_valid", 64'(rif.rpt_valid), 64'(m_valid));
            if (m_valid) begin
               chk("rpt_idx", 64'(rif.rpt_idx), 64'(m_idx));
               chk("rpt_ts", 64'(rif.rpt_ts), 64'(m_rts));
            end
            chk("sticky", 64'(sticky), 64'(m_sticky));
            chk("deadlock_any", 64'(deadlock_any), 64'(m_any));
            if (hold) begin
               chk("hold_valid", 64'(rif.rpt_valid), 64'd1);
               chk("hold_idx", 64'(rif.rpt_idx), 64'(h_idx));
               chk("hold_ts", 64'(rif.rpt_ts), 64'(h_ts));
            end
            hold  = rif.rpt_valid && !rif.rpt_ready && !reset;
            h_idx = 32'(rif.rpt_idx);
            h_ts  = rif.rpt_ts;
            if (rif.rpt_valid && rif.rpt_ready && !reset)
               log_q.push_back({32'(rif.rpt_idx), rif.rpt_ts});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1; enable = 0; clear = 0; mon_block = 0;
      rif.rpt_ready = 1;
      tick(2);
      reset = 0;
      log_q.delete();
   endtask

   initial begin
      // single monitor held past the threshold
      do_reset();
      enable = 1; mon_block = 8'h08;
      tick(20); mon_block = 0;
      tick(10);
      chk("t1_count", 64'(log_q.size()), 64'd1);
      exp_rep("t1_r0", 0, 3, 15);
      chk("t1_sticky", 64'(sticky), 64'h08);
      chk("t1_any", 64'(deadlock_any), 64'd1);

      // one-cycle dropout restarts the count
      do_reset();
      enable = 1; mon_block = 8'h20;
      tick(15); mon_block = 0;
      tick(1);  mon_block = 8'h20;
      tick(16); mon_block = 0;
      tick(8);
      chk("t2_count", 64'(log_q.size()), 64'd1);
      exp_rep("t2_r0", 0, 5, 31);
      chk("t2_sticky", 64'(sticky), 64'h20);

      // simultaneous confirms, then pointer wrap from 7
      do_reset();
      enable = 1; mon_block = 8'h52;
      tick(16); mon_block = 0;
      tick(20); mon_block = 8'h81;
      tick(16); mon_block = 0;
      tick(10);
      chk("t3_count", 64'(log_q.size()), 64'd5);
      exp_rep("t3_r0", 0, 1, 15);
      exp_rep("t3_r1", 1, 4, 15);
      exp_rep("t3_r2", 2, 6, 15);
      exp_rep("t3_r3", 3, 7, 51);
      exp_rep("t3_r4", 4, 0, 51);
      chk("t3_sticky", 64'(sticky), 64'hD3);

      // consumer stalls for ten cycles
      do_reset();
      enable = 1; rif.rpt_ready = 0; mon_block = 8'h04;
      tick(16); mon_block = 0;
      tick(12); rif.rpt_ready = 1;
      tick(5);
      chk("t4_count", 64'(log_q.size()), 64'd1);
      exp_rep("t4_r0", 0, 2, 15);

      // clear during REPORT with two still pending
      do_reset();
      enable = 1; rif.rpt_ready = 0; mon_block = 8'h25;
      tick(16); mon_block = 0;
      tick(4);  clear = 1;
      tick(1);  clear = 0;
      tick(2);  rif.rpt_ready = 1;
      tick(10);
      chk("t5_count", 64'(log_q.size()), 64'd1);
      exp_rep("t5_r0", 0, 0, 15);
      chk("t5_sticky", 64'(sticky), 64'h00);
      chk("t5_any", 64'(deadlock_any), 64'd0);

      // clear in the confirm cycle wins
      do_reset();
      enable = 1; mon_block = 8'h08;
      tick(15); clear = 1;
      tick(1);  clear = 0; mon_block = 0;
      tick(8);
      chk("t6_count", 64'(log_q.size()), 64'd0);
      chk("t6_sticky", 64'(sticky), 64'h00);

      // reset mid-REPORT, then timestamp restarts at 0
      do_reset();
      enable = 1; rif.rpt_ready = 0; mon_block = 8'h40;
      tick(16); mon_block = 0;
      tick(4);  reset = 1;
      tick(1);
      chk("t7_valid", 64'(rif.rpt_valid), 64'd0);
      chk("t7_sticky", 64'(sticky), 64'h00);
      chk("t7_any", 64'(deadlock_any), 64'd0);
      reset = 0; rif.rpt_ready = 1; mon_block = 8'h02;
      tick(16); mon_block = 0;
      tick(8);
      chk("t7_count", 64'(log_q.size()), 64'd1);
      exp_rep("t7_r0", 0, 1, 15);
      chk("t7_sticky2", 64'(sticky), 64'h02);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
